pattern_stream_gen: RTL
=======================

// Module: pattern_stream_gen
// PURPOSE
//  Parametrised multi-pixel test-pattern source with valid/ready backpressure.
//  It owns its own x/y raster counters and emits PACK_NUM pixels per beat.
//  Each pattern is latched only at start-of-frame.
//  It feeds the video FIFO / packer chain in place of a camera input for bring-up and BIST.
// PARAMETERS
//  PIXEL_BIT   24    bits per pixel (<=32)
//  PACK_NUM    2     pixels per output beat (>=1); H_ACTIVE % PACK_NUM == 0
//  CNT_WIDTH   12    width of x/y counters; 2**CNT_WIDTH > max(H_ACTIVE,V_ACTIVE)
//  H_ACTIVE    1920  active pixels per line (>=8)
//  V_ACTIVE    1080  active lines per frame (>=8)
// PORTS
//  in_pclk        in   1                    pixel clock, all logic rising-edge
//  in_rst         in   1                    reset, asynchronous, active-high
//  in_enable      in   1                    run request; sampled at frame boundaries only
//  in_pattern     in   3                    pattern select; latched at SOF beat
//  out_ready      in   1                    sink accepts beat when out_valid&&out_ready
//  out_valid      out  1                    beat valid
//  out_data       out  PACK_NUM*PIXEL_BIT   lane k = bits [k*PIXEL_BIT +: PIXEL_BIT] = pixel x+k
//  out_x          out  CNT_WIDTH            x of lane 0 (steps by PACK_NUM)
//  out_y          out  CNT_WIDTH            line number
//  out_sof        out  1                    beat is first of frame (x=0,y=0)
//  out_eol        out  1                    beat is last of line (x=H_ACTIVE-PACK_NUM)
//  out_frame_cnt  out  8                    completed frames, wraps 255->0
// BEHAVIOUR
//  Clock/reset: one clock in_pclk; reset in_rst is asynchronous and active-high.
//  Reset: all outputs 0, FSM=IDLE, x=y=0, LFSR=32'hFFFFFFFF, latched pattern=0.
//  Reset asserted mid-frame: outputs clear immediately; no partial-frame resume.
//  FSM
//   - IDLE: if in_enable then RUN; out_valid=0.
//   - RUN: generate beats.
//   - After the last beat of a frame is accepted (x=H_ACTIVE-PACK_NUM, y=V_ACTIVE-1):
//     out_frame_cnt++; stay in RUN if in_enable=1, else go to IDLE.
//   - in_enable deasserted mid-frame: the frame completes, then the block idles.
//  Handshake and latency
//   - Registered output stage. A new beat loads when (!out_valid || out_ready).
//   - While out_valid && !out_ready, every output holds stable.
//   - out_valid never drops without acceptance, except on reset.
//   - First beat: out_valid=1 on the 2nd rising edge after in_enable is seen high in IDLE
//     (IDLE->RUN, then load). Sustained throughput is 1 beat/clk with out_ready=1.
//  Raster counters
//   - x advances by PACK_NUM per loaded beat.
//   - x wraps to 0 at H_ACTIVE; y increments on that wrap; y wraps to 0 at V_ACTIVE.
//  Pattern latch: in_pattern is captured into pat_q when the SOF beat loads; it is
//   constant for the whole frame.
//  Grey levels: L(i) = ((2**PIXEL_BIT-1)/7)*i for i=0..6; L(7) = all ones.
//  Patterns (per lane k, px = x+k):
//   - 0: L(out_frame_cnt[6:4]); all pixels of the frame are equal.
//   - 1: L(min(y/(V_ACTIVE/8),7)), horizontal bands.
//   - 2: L(min(px/(H_ACTIVE/8),7)), vertical bars; lanes in one beat may differ.
//   - 3: (px+y) zero-extended or truncated to PIXEL_BIT.
//   - 4: Galois LFSR, poly 32'h04C11DB7, shift left.
//     * Lane k = low PIXEL_BIT bits of the state after k+1 steps from the current state.
//     * On each loaded beat the state advances PACK_NUM steps.
//     * The state reseeds to 32'hFFFFFFFF on every SOF load, so every frame is identical.
//   - 5: checkerboard: (px[3]^y[3]) ? all ones : 0.
//   - 6: all zero.
//   - 7: all ones.
//  Width rules: x+k and bar/band compares use CNT_WIDTH+1 bits (no overflow); divisors
//   are elaboration-time constants.
// TESTING
//  1. Reset defaults: in_rst pulse mid-beat -> all outputs 0 asynchronously, FSM=IDLE.
//  2. Raster: H=16,V=8,PACK=2, pattern=3, out_ready=1.
//     -> 64 beats, SOF on beat 0, EOL every 8th, lane1 = lane0+1, frame_cnt=1.
//  3. Backpressure: random out_ready (50%).
//     -> the beat sequence equals the out_ready=1 run; outputs are stable while stalled.
//  4. Pattern latch: change in_pattern 2->5 mid-frame.
//     -> the current frame stays bars; the next SOF starts the checkerboard.
//  5. LFSR: pattern=4, two frames.
//     -> lane0 of beat 0 = low bits of 1 step from 32'hFFFFFFFF; frame 2 is byte-identical.
//  6. Enable drop: deassert in_enable at y=3.
//     -> frame finishes, out_frame_cnt increments, then out_valid=0 with FSM in IDLE.

Source files
------------

// File: rtl/pattern_stream_gen_if.sv
// Output stream bundle of the test-pattern generator.
// Beat payload and raster tags with a valid/ready handshake.
interface pattern_stream_gen_if #(
  parameter int PIXEL_BIT = 24,
  parameter int PACK_NUM  = 2,
  parameter int CNT_WIDTH = 12
);
  logic                          out_valid;
  logic                          out_ready;
  logic [PACK_NUM*PIXEL_BIT-1:0] out_data;
  logic [CNT_WIDTH-1:0]          out_x;
  logic [CNT_WIDTH-1:0]          out_y;
  logic                          out_sof;
  logic                          out_eol;
  logic [7:0]                    out_frame_cnt;

  modport master (
    output out_valid, out_data, out_x, out_y,
    output out_sof, out_eol, out_frame_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_x, out_y,
    input  out_sof, out_eol, out_frame_cnt,
    output out_ready
  );
endinterface

// File: rtl/pattern_stream_gen.sv
// Multi-pixel test-pattern source with its own raster counters.
// Pattern and LFSR seed are latched on the start-of-frame beat.
module pattern_stream_gen #(
  parameter int PIXEL_BIT = 24,
  parameter int PACK_NUM  = 2,
  parameter int CNT_WIDTH = 12,
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080
) (
  input  logic       in_pclk,
  input  logic       in_rst,
  input  logic       in_enable,
  input  logic [2:0] in_pattern,
  pattern_stream_gen_if.master strm
);
  localparam int CW  = CNT_WIDTH;
  localparam int CW1 = CNT_WIDTH + 1;
  localparam int DW  = PACK_NUM * PIXEL_BIT;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [PIXEL_BIT-1:0] ONES = '1;
  localparam logic [PIXEL_BIT-1:0] STEP = ONES / PIXEL_BIT'(7);
  localparam logic [CW1-1:0] BAR  = CW1'(H_ACTIVE / 8);
  localparam logic [CW1-1:0] BAND = CW1'(V_ACTIVE / 8);
  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - PACK_NUM);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] X_STEP = CW'(PACK_NUM);

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [PIXEL_BIT-1:0] grey(input logic [2:0] i);
    return (i == 3'd7) ? ONES : STEP * PIXEL_BIT'(i);
  endfunction

  function automatic logic [2:0] clamp7(input logic [CW1-1:0] v);
    return (v > CW1'(7)) ? 3'd7 : v[2:0];
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [2:0]      pat_q, pat_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic            sof_q, sof_d, eol_q, eol_d;
  logic [7:0]      fcnt_q, fcnt_d;

  logic            origin, load, last_acc;
  logic [2:0]      pat;
  logic [31:0]     s;
  logic [CW1-1:0]  px, y_ext;
  logic [PIXEL_BIT-1:0] lane;

  assign origin   = (x_q == '0) && (y_q == '0);
  assign last_acc = valid_q && strm.out_ready && eol_q && (oy_q == Y_LAST);
  assign y_ext    = CW1'(y_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lfsr_d  = lfsr_q;
    pat_d   = pat_q;
    valid_d = valid_q;
    data_d  = data_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    fcnt_d  = fcnt_q + 8'(last_acc);
    load    = 1'b0;
    pat     = origin ? in_pattern : pat_q;
    s       = origin ? SEED : lfsr_q;
    px      = '0;
    lane    = '0;

    unique case (state_q)
      IDLE: begin
        if (strm.out_ready) valid_d = 1'b0;
        if (in_enable) state_d = RUN;
      end
      RUN: begin
        if (!valid_q || strm.out_ready) begin
          // enable only matters where a new frame would start
          if (origin && !in_enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      for (int k = 0; k < PACK_NUM; k++) begin
        px = CW1'(x_q) + CW1'(k);
        s  = lfsr_next(s);
        unique case (pat)
          3'd0: lane = grey(fcnt_d[6:4]);
          3'd1: lane = grey(clamp7(y_ext / BAND));
          3'd2: lane = grey(clamp7(px / BAR));
          3'd3: lane = PIXEL_BIT'(32'(px) + 32'(y_q));
          3'd4: lane = s[PIXEL_BIT-1:0];
          3'd5: lane = {PIXEL_BIT{px[3] ^ y_q[3]}};
          3'd6: lane = '0;
          3'd7: lane = ONES;
        endcase
        data_d[k*PIXEL_BIT +: PIXEL_BIT] = lane;
      end
      lfsr_d  = s;
      pat_d   = pat;
      valid_d = 1'b1;
      ox_d    = x_q;
      oy_d    = y_q;
      sof_d   = origin;
      eol_d   = (x_q == X_LAST);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + X_STEP;
      end
    end
  end

  always_ff @(posedge in_pclk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      lfsr_q  <= SEED;
      pat_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lfsr_q  <= lfsr_d;
      pat_q   <= pat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign strm.out_valid     = valid_q;
  assign strm.out_data      = data_q;
  assign strm.out_x         = ox_q;
  assign strm.out_y         = oy_q;
  assign strm.out_sof       = sof_q;
  assign strm.out_eol       = eol_q;
  assign strm.out_frame_cnt = fcnt_q;
endmodule
